// File: rtl/conf_editor_if.sv
// Register-bank access port between the configuration editor (master) and
// the timing register bank (slave).
interface conf_editor_if #(
  parameter int DIGITS = 6
);
  logic [2:0]          selected_index;
  logic [DIGITS*4-1:0] selected_value;
  logic [DIGITS*4-1:0] selected_new_value;
  logic                selected_set;
  logic                conf_ready;

  modport master (
    output selected_index,
    output selected_new_value,
    output selected_set,
    input  selected_value,
    input  conf_ready
  );

  modport slave (
    input  selected_index,
    input  selected_new_value,
    input  selected_set,
    output selected_value,
    output conf_ready
  );
endinterface

// File: rtl/conf_editor.sv
// Front-panel editor for the timing register bank: browse entries, edit BCD
// digits in a local buffer, and commit with a one-cycle write strobe.
module conf_editor #(
  parameter int DIGITS  = 6,
  parameter int ENTRIES = 5,
  parameter int SETTLE  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                btn_entry,
  input  logic                btn_digit,
  input  logic                btn_inc,
  input  logic                btn_dec,
  input  logic                btn_edit,
  input  logic                btn_cancel,
  conf_editor_if.master       bank,
  output logic [DIGITS*4-1:0] display_value,
  output logic [2:0]          cursor,
  output logic                editing,
  output logic                busy
);
  localparam int W  = DIGITS * 4;
  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW:0] SETTLE_V = (CW + 1)'(SETTLE);

  typedef enum logic [1:0] {BROWSE, EDIT, COMMIT, WAIT} state_t;

  state_t        state;
  logic [W-1:0]  buffer;
  logic [W-1:0]  edited;
  logic [CW-1:0] settle_cnt;
  logic [CW:0]   settle_next;
  logic [3:0]    cur_nibble;
  logic [3:0]    inc_nibble;
  logic [3:0]    dec_nibble;

  // Digit under the cursor and the buffer with that digit stepped; a
  // non-BCD nibble snaps to 0 on increment and 9 on decrement.
  always_comb begin
    cur_nibble = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (cursor == 3'(i)) cur_nibble = buffer[i*4 +: 4];
    inc_nibble = (cur_nibble >= 4'd9) ? 4'd0 : cur_nibble + 4'd1;
    dec_nibble = (cur_nibble == 4'd0 || cur_nibble > 4'd9) ? 4'd9 : cur_nibble - 4'd1;
    edited = buffer;
    for (int i = 0; i < DIGITS; i++)
      if (cursor == 3'(i)) edited[i*4 +: 4] = btn_inc ? inc_nibble : dec_nibble;
  end

  assign settle_next = {1'b0, settle_cnt} + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= BROWSE;
      bank.selected_index <= '0;
      bank.selected_set   <= 1'b0;
      buffer              <= '0;
      cursor              <= '0;
      editing             <= 1'b0;
      busy                <= 1'b0;
      settle_cnt          <= '0;
    end else if (ce) begin
      case (state)
        BROWSE: begin
          if (btn_edit) begin
            buffer  <= bank.selected_value;
            cursor  <= '0;
            editing <= 1'b1;
            state   <= EDIT;
          end else if (btn_entry) begin
            bank.selected_index <= (bank.selected_index == 3'(ENTRIES - 1)) ?
                                   3'd0 : bank.selected_index + 3'd1;
          end
        end
        EDIT: begin
          if (btn_cancel) begin
            editing <= 1'b0;
            state   <= BROWSE;
          end else if (btn_edit) begin
            editing <= 1'b0;
            busy    <= 1'b1;
            state   <= COMMIT;
          end else if (btn_digit) begin
            cursor <= (cursor == 3'(DIGITS - 1)) ? 3'd0 : cursor + 3'd1;
          end else if (btn_inc ^ btn_dec) begin
            buffer <= edited;
          end
        end
        COMMIT: begin
          if (bank.conf_ready) begin
            bank.selected_set <= 1'b1;
            settle_cnt        <= '0;
            state             <= WAIT;
          end
        end
        WAIT: begin
          // The strobe lasts exactly one ce cycle; the counter saturates so a
          // long conversion cannot wrap it back below the settle threshold.
          bank.selected_set <= 1'b0;
          settle_cnt <= (settle_next >= SETTLE_V) ? SETTLE_V[CW-1:0] : settle_next[CW-1:0];
          if (settle_next >= SETTLE_V && bank.conf_ready) begin
            busy  <= 1'b0;
            state <= BROWSE;
          end
        end
        default: state <= BROWSE;
      endcase
    end
  end

  assign bank.selected_new_value = buffer;
  assign display_value = (state == BROWSE) ? bank.selected_value : buffer;
endmodule

// File: tb/tb_conf_editor.sv
// Self-checking bench for conf_editor: register-bank stand-in, behavioural
// model, per-cycle compare, directed scenarios and randomized stimulus.
module tb_conf_editor;
  localparam int DIGITS  = 6;
  localparam int ENTRIES = 5;
  localparam int SETTLE  = 2;

  localparam logic [5:0] B_NONE   = 6'b000000;
  localparam logic [5:0] B_ENTRY  = 6'b000001;
  localparam logic [5:0] B_DIGIT  = 6'b000010;
  localparam logic [5:0] B_INC    = 6'b000100;
  localparam logic [5:0] B_DEC    = 6'b001000;
  localparam logic [5:0] B_EDIT   = 6'b010000;
  localparam logic [5:0] B_CANCEL = 6'b100000;

  localparam int M_BROWSE = 0;
  localparam int M_EDIT   = 1;
  localparam int M_COMMIT = 2;
  localparam int M_WAIT   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b1;
  logic btn_entry = 1'b0, btn_digit = 1'b0, btn_inc = 1'b0;
  logic btn_dec = 1'b0, btn_edit = 1'b0, btn_cancel = 1'b0;
  logic conf_ready = 1'b1;
  logic [23:0] display_value;
  logic [2:0]  cursor;
  logic        editing;
  logic        busy;

  int tests = 0;
  int failures = 0;
  int set_edges = 0;

  conf_editor_if #(.DIGITS(DIGITS)) bank_if ();

  conf_editor #(.DIGITS(DIGITS), .ENTRIES(ENTRIES), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .btn_entry(btn_entry), .btn_digit(btn_digit), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .btn_edit(btn_edit), .btn_cancel(btn_cancel),
    .bank(bank_if),
    .display_value(display_value), .cursor(cursor),
    .editing(editing), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register bank stand-in: combinational read, write on a ce edge with set high.
  logic [23:0] env_mem [0:4] = '{24'h001000, 24'h003400, 24'h12345B, 24'h987654, 24'hA0F909};
  assign bank_if.selected_value = (bank_if.selected_index < 3'd5) ? env_mem[bank_if.selected_index] : 24'h0;
  assign bank_if.conf_ready = conf_ready;

  always @(posedge clk)
    if (!rst && ce && bank_if.selected_set === 1'b1)
      env_mem[bank_if.selected_index] <= bank_if.selected_new_value;

  always @(posedge clk)
    if (!rst && ce && bank_if.selected_set === 1'b1) set_edges++;

  // Behavioural model: mode, entry index, cursor and the edit buffer as a digit list.
  int          m_mode = M_BROWSE;
  int          m_idx = 0;
  int          m_cur = 0;
  int          m_wait = 0;
  bit          m_set = 1'b0;
  logic [3:0]  m_dig [DIGITS] = '{default: 4'd0};
  logic [23:0] m_mem [0:4] = '{24'h001000, 24'h003400, 24'h12345B, 24'h987654, 24'hA0F909};

  function automatic logic [23:0] m_buffer();
    logic [23:0] r;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = m_dig[i];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_BROWSE; m_idx = 0; m_cur = 0; m_wait = 0; m_set = 1'b0;
      for (int i = 0; i < DIGITS; i++) m_dig[i] = 4'd0;
    end else if (ce) begin
      if (m_set) begin
        m_mem[m_idx] = m_buffer();
        m_set = 1'b0;
      end
      case (m_mode)
        M_BROWSE: begin
          if (btn_edit) begin
            for (int i = 0; i < DIGITS; i++) m_dig[i] = m_mem[m_idx][i*4 +: 4];
            m_cur = 0;
            m_mode = M_EDIT;
          end else if (btn_entry) m_idx = (m_idx + 1) % ENTRIES;
        end
        M_EDIT: begin
          if (btn_cancel) m_mode = M_BROWSE;
          else if (btn_edit) m_mode = M_COMMIT;
          else if (btn_digit) m_cur = (m_cur + 1) % DIGITS;
          else if (btn_inc && !btn_dec) m_dig[m_cur] = (m_dig[m_cur] > 4'd8) ? 4'd0 : m_dig[m_cur] + 4'd1;
          else if (btn_dec && !btn_inc) m_dig[m_cur] = (m_dig[m_cur] == 4'd0 || m_dig[m_cur] > 4'd9) ? 4'd9 : m_dig[m_cur] - 4'd1;
        end
        M_COMMIT: begin
          if (conf_ready) begin
            m_set = 1'b1;
            m_wait = 0;
            m_mode = M_WAIT;
          end
        end
        default: begin
          m_wait++;
          if (m_wait >= SETTLE && conf_ready) m_mode = M_BROWSE;
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("index", 32'(bank_if.selected_index), 32'(m_idx));
      checkOutput("set", 32'(bank_if.selected_set), 32'(m_set));
      checkOutput("new_value", 32'(bank_if.selected_new_value), 32'(m_buffer()));
      checkOutput("display", 32'(display_value), 32'((m_mode == M_BROWSE) ? m_mem[m_idx] : m_buffer()));
      checkOutput("cursor", 32'(cursor), 32'(m_cur));
      checkOutput("editing", 32'(editing), 32'(m_mode == M_EDIT));
      checkOutput("busy", 32'(busy), 32'(m_mode == M_COMMIT || m_mode == M_WAIT));
    end
  end

  task automatic applyStimulus(input logic [5:0] b, input logic ce_v, input logic rdy_v);
    {btn_cancel, btn_edit, btn_dec, btn_inc, btn_digit, btn_entry} = b;
    ce = ce_v;
    conf_ready = rdy_v;
    @(posedge clk);
    #2;
    {btn_cancel, btn_edit, btn_dec, btn_inc, btn_digit, btn_entry} = B_NONE;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_index"}, 32'(bank_if.selected_index), 32'd0);
    checkOutput({tag, "_set"}, 32'(bank_if.selected_set), 32'd0);
    checkOutput({tag, "_new_value"}, 32'(bank_if.selected_new_value), 32'd0);
    checkOutput({tag, "_cursor"}, 32'(cursor), 32'd0);
    checkOutput({tag, "_editing"}, 32'(editing), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_display"}, 32'(display_value), 32'h001000);
  endtask

  initial begin
    logic [5:0] b;
    #3;
    checkReset("reset");
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    // Browse wrap, other buttons ignored in browse
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(B_ENTRY, 1'b1, 1'b1);
      checkOutput("wrap_index", 32'(bank_if.selected_index), 32'(i % 5));
    end
    applyStimulus(B_DIGIT, 1'b1, 1'b1);
    applyStimulus(B_INC, 1'b1, 1'b1);
    checkOutput("browse_ignore_cursor", 32'(cursor), 32'd0);
    checkOutput("browse_ignore_display", 32'(display_value), 32'h001000);

    // Digit edit without borrow, then cursor wrap
    applyStimulus(B_EDIT, 1'b1, 1'b1);
    checkOutput("edit_load", 32'(bank_if.selected_new_value), 32'h001000);
    checkOutput("edit_flag", 32'(editing), 32'd1);
    repeat (3) applyStimulus(B_DIGIT, 1'b1, 1'b1);
    repeat (2) applyStimulus(B_DEC, 1'b1, 1'b1);
    checkOutput("edit_cursor", 32'(cursor), 32'd3);
    checkOutput("edit_buffer", 32'(bank_if.selected_new_value), 32'h009000);
    repeat (5) applyStimulus(B_DIGIT, 1'b1, 1'b1);
    checkOutput("cursor_wrap", 32'(cursor), 32'd2);
    applyStimulus(B_CANCEL, 1'b1, 1'b1);
    checkOutput("cancel_display", 32'(display_value), 32'h001000);

    // Commit handshake with conf_ready stalls
    applyStimulus(B_ENTRY, 1'b1, 1'b1);
    applyStimulus(B_EDIT, 1'b1, 1'b1);
    repeat (2) applyStimulus(B_DIGIT, 1'b1, 1'b1);
    applyStimulus(B_INC, 1'b1, 1'b1);
    checkOutput("commit_buffer", 32'(bank_if.selected_new_value), 32'h003500);
    applyStimulus(B_EDIT, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_busy", 32'(busy), 32'd1);
      checkOutput("stall_set", 32'(bank_if.selected_set), 32'd0);
      applyStimulus(B_NONE, 1'b1, 1'b0);
    end
    applyStimulus(B_NONE, 1'b1, 1'b1);
    checkOutput("strobe_set", 32'(bank_if.selected_set), 32'd1);
    checkOutput("strobe_value", 32'(bank_if.selected_new_value), 32'h003500);
    checkOutput("strobe_index", 32'(bank_if.selected_index), 32'd1);
    applyStimulus(B_NONE, 1'b1, 1'b0);
    checkOutput("strobe_drop", 32'(bank_if.selected_set), 32'd0);
    repeat (3) applyStimulus(B_NONE, 1'b1, 1'b0);
    checkOutput("wait_hold_busy", 32'(busy), 32'd1);
    applyStimulus(B_NONE, 1'b1, 1'b1);
    checkOutput("commit_done_busy", 32'(busy), 32'd0);
    checkOutput("commit_written", 32'(display_value), 32'h003500);

    // Settle minimum with conf_ready held high: two ce cycles in WAIT
    applyStimulus(B_EDIT, 1'b1, 1'b1);
    applyStimulus(B_EDIT, 1'b1, 1'b1);
    applyStimulus(B_NONE, 1'b1, 1'b1);
    applyStimulus(B_NONE, 1'b1, 1'b1);
    checkOutput("settle_min_busy", 32'(busy), 32'd1);
    applyStimulus(B_NONE, 1'b1, 1'b1);
    checkOutput("settle_done_busy", 32'(busy), 32'd0);

    // Cancel priority, inc+dec, non-BCD nibble
    applyStimulus(B_ENTRY, 1'b1, 1'b1);
    applyStimulus(B_EDIT, 1'b1, 1'b1);
    applyStimulus(B_CANCEL | B_EDIT, 1'b1, 1'b1);
    checkOutput("cancel_prio_busy", 32'(busy), 32'd0);
    checkOutput("cancel_prio_editing", 32'(editing), 32'd0);
    applyStimulus(B_EDIT, 1'b1, 1'b1);
    applyStimulus(B_INC | B_DEC, 1'b1, 1'b1);
    checkOutput("incdec_same", 32'(bank_if.selected_new_value), 32'h12345B);
    applyStimulus(B_INC, 1'b1, 1'b1);
    checkOutput("nonbcd_inc", 32'(bank_if.selected_new_value), 32'h123450);
    applyStimulus(B_DEC, 1'b1, 1'b1);
    checkOutput("dec_wrap", 32'(bank_if.selected_new_value), 32'h123459);
    applyStimulus(B_CANCEL, 1'b1, 1'b1);

    // Clock enable gating
    applyStimulus(B_EDIT, 1'b0, 1'b1);
    applyStimulus(B_ENTRY, 1'b0, 1'b1);
    checkOutput("ce_low_editing", 32'(editing), 32'd0);
    checkOutput("ce_low_index", 32'(bank_if.selected_index), 32'd2);
    set_edges = 0;
    for (int cyc = 0; cyc < 40; cyc++)
      applyStimulus((cyc == 0 || cyc == 4) ? B_EDIT : B_NONE, (cyc % 4) == 0, 1'b1);
    checkOutput("ce_set_edges", 32'(set_edges), 32'd1);
    checkOutput("ce_commit_busy", 32'(busy), 32'd0);

    // Async reset while the write strobe is high
    applyStimulus(B_EDIT, 1'b1, 1'b1);
    applyStimulus(B_EDIT, 1'b1, 1'b1);
    applyStimulus(B_NONE, 1'b1, 1'b1);
    checkOutput("pre_reset_set", 32'(bank_if.selected_set), 32'd1);
    rst = 1'b1;
    #1;
    checkReset("async_reset");
    #3;
    rst = 1'b0;
    @(posedge clk); #2;

    // Randomized stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 6; k++) b[k] = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 3) != 0) b[5] = 1'b0;
      applyStimulus(b, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
    end
    applyStimulus(B_NONE, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule

// File: doc/conf_editor.md
# conf_editor

Initiator side of the configuration register-bank access port (`selected_index` / `selected_value` / `selected_new_value` / `selected_set`). Turns debounced front-panel button pulses into browse, BCD digit edit and commit operations on the five timing entries (dit, dah, word, tolerance, pulses-per-unit). It drives the display path with the value being browsed or edited. It holds off further commits until the bank reports its derived timings `ready` again.

## Interface
Parameters:
- `DIGITS`, 6: BCD digits per entry; data width is `DIGITS*4` (24, matching `UNIT_BCD_W`).
- `ENTRIES`, 5: number of bank entries; valid indices are 0..ENTRIES-1.
- `SETTLE`, 2: minimum ce cycles spent in WAIT before `conf_ready` is sampled.

Ports:
- `clk`  in  1  system clock; the design has a single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ce`  in  1  clock enable; all state changes occur only on `clk` edges with `ce`=1.
- `btn_entry`  in  1  pulse: select the next entry (browse only).
- `btn_digit`  in  1  pulse: move the cursor to the next more-significant digit (edit only).
- `btn_inc`  in  1  pulse: increment the digit under the cursor.
- `btn_dec`  in  1  pulse: decrement the digit under the cursor.
- `btn_edit`  in  1  pulse: enter edit mode (browse) or commit (edit).
- `btn_cancel`  in  1  pulse: discard the edit and return to browse.
- `selected_index`  out  3  entry addressed in the bank.
- `selected_value`  in  DIGITS*4  current value of the addressed entry; combinational from the bank.
- `selected_new_value`  out  DIGITS*4  edit buffer, driven continuously.
- `selected_set`  out  1  write strobe.
- `conf_ready`  in  1  bank timing conversion complete.
- `display_value`  out  DIGITS*4  value to show on the display.
- `cursor`  out  3  active digit index; 0 is the least-significant digit.
- `editing`  out  1  high in the EDIT state.
- `busy`  out  1  high in the COMMIT and WAIT states.

## Operation
- States: BROWSE, EDIT, COMMIT, WAIT.
- BROWSE:
  - `btn_entry`: `selected_index` increments; ENTRIES-1 wraps to 0.
  - `btn_edit`: buffer <= `selected_value`, cursor <= 0, go to EDIT. This takes priority over `btn_entry` in the same cycle.
  - All other buttons are ignored.
- EDIT: priority is `btn_cancel` > `btn_edit` > `btn_digit` > `btn_inc`/`btn_dec`.
  - `btn_cancel`: go to BROWSE; the buffer is not written to the bank.
  - `btn_edit`: go to COMMIT.
  - `btn_digit`: cursor increments; DIGITS-1 wraps to 0.
  - `btn_inc`: the digit under the cursor becomes 9→0 or d→d+1. There is no carry into neighbouring digits.
  - `btn_dec`: the digit under the cursor becomes 0→9 or d→d-1. There is no borrow.
  - `btn_inc` and `btn_dec` together: no change.
  - A non-BCD nibble (A–F) under the cursor becomes 0 on inc and 9 on dec.
  - `btn_entry` is ignored.
- COMMIT:
  - If `conf_ready`=1: assert `selected_set`, load the settle counter with 0, go to WAIT.
  - Otherwise remain in COMMIT.
  - All buttons are ignored.
- WAIT:
  - The settle counter increments on each ce cycle.
  - Once the count reaches SETTLE and `conf_ready`=1, go to BROWSE.
  - All buttons are ignored.
- `selected_index` never changes outside BROWSE. It is therefore stable while `selected_set` is high and while the bank converts.
- `display_value` is `selected_value` in BROWSE and the buffer in every other state.
- Reset values: state BROWSE, `selected_index` 0, buffer 0, cursor 0, `selected_set` 0, `editing` 0, `busy` 0, settle counter 0.
- Reset mid-edit or mid-commit returns asynchronously to BROWSE with all of the above values. A pending edit is lost. `selected_set` drops immediately.

## Timing
- All outputs are registered except `selected_new_value` (the buffer register itself) and `display_value` (a mux).
- Button effects are visible after the edge of the ce cycle in which the button is high. Button pulses with `ce`=0 are ignored.
- `selected_set` rises at the ce edge that leaves COMMIT and falls at the next ce edge. The bank therefore samples it in exactly one ce cycle, with `selected_new_value` and `selected_index` stable.
- Commit latency with `conf_ready`=1 throughout:
  - `btn_edit` in EDIT at ce cycle n: COMMIT after n.
  - `selected_set` high after ce cycle n+1.
  - Bank write occurs at ce cycle n+2.
  - BROWSE is entered no earlier than ce cycle n+1+SETTLE, and only when `conf_ready`=1.
- `conf_ready` low in COMMIT stalls indefinitely, with no timeout.

## Test plan
- Browse wrap: after reset, 5 `btn_entry` pulses → `selected_index` goes 1,2,3,4,0. `btn_digit`/`btn_inc` in BROWSE change nothing.
- Digit edit: index 0, `selected_value`=0x001000.
  - Stimulus: `btn_edit`, then 3×`btn_digit`, then 2×`btn_dec`.
  - Required: cursor=3 and buffer=0x009000 (1→0→9, no borrow).
  - Then 5×`btn_digit` → cursor wraps to 2.
- Commit handshake:
  - Stimulus: `conf_ready`=0 while `btn_edit` is pressed in EDIT with buffer 0x003500.
  - Required: `busy`=1 and `selected_set`=0 are held.
  - Then raise `conf_ready` → exactly one ce cycle of `selected_set` with `selected_new_value`=0x003500, `selected_index` unchanged.
  - Return to BROWSE only after ≥SETTLE ce cycles and `conf_ready`=1.
- Cancel and priority:
  - `btn_cancel` with `btn_edit` in the same cycle → BROWSE, no `selected_set`.
  - `btn_inc` with `btn_dec` → digit unchanged.
  - Digit 0xB with `btn_inc` → 0.
- Clock enable: pulses with `ce`=0 → no state change. With `ce` toggling every 4th cycle, `selected_set` is high across exactly one ce edge.
- Async reset asserted in WAIT while `selected_set`=1 → all outputs return to reset values immediately, before the next `clk` edge.
